rle_stream_enc: RTL and testbench
=================================

// Module: rle_stream_enc
// PURPOSE
//  Parametrised run-length encoder on the sample stream, between sampler/trigger and shifter.
//  Collapses repeated samples (compared under a channel mask) into one value word plus a count word.
//  Count words carry MSB=1; value words carry MSB=0. Trigger and tlast positions are preserved exactly.
//  Transparent registered pass-through when disabled.
// PARAMETERS
//  DW  32  sample/word width; bit DW-1 is the RLE flag when enabled
//  CW  16  run counter width, CW <= DW-1 (elaboration error otherwise)
// PORTS
//  clk          in   1   clock, single domain
//  rst          in   1   reset, asynchronous, active-low
//  cfg_ena      in   1   1=RLE on, 0=pass-through
//  cfg_mask     in   DW  compare mask; 1=channel participates; bit DW-1 ignored
//  cfg_limit    in   CW  run saturation limit; 0 means 2^CW-1
//  ctl_arm      in   1   sync clear of run state and output register
//  sti_tready   out  1   input ready
//  sti_tvalid   in   1   input valid
//  sti_tlast    in   1   last sample of capture
//  sti_trigger  in   1   sample is the trigger point
//  sti_tdata    in   DW  sample
//  sto_tready   in   1   output ready
//  sto_tvalid   out  1   output valid
//  sto_tlast    out  1   last word
//  sto_trigger  out  1   word carries trigger sample
//  sto_tdata    out  DW  value or count word
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, state S_IDLE, count=0, prev invalid. ctl_arm: same, synchronously.
//  Handshake: word moves on tvalid&tready. Outputs stable while sto_tvalid&~sto_tready.
//  sti_tready = (~sto_tvalid | sto_tready) & (state != S_PEND).
//  cfg_ena=0: each input copied unchanged to output register, 1-cycle latency, full throughput.
//  cfg_ena=1, masked compare eq = ((sti_tdata ^ prev) & cfg_mask & ~MSB) == 0:
//   value word = {1'b0, sti_tdata[DW-2:0]}; count word = {1'b1, zero-pad, count[CW-1:0]}.
//   S_IDLE: accepted sample emitted as value word (latency 1), prev<=data -> S_RUN.
//   S_RUN, eq & ~trigger & ~tlast: no output, count++. If count+1 == limit: emit count word, count<=0.
//   S_RUN, ~eq | trigger | tlast (break): count==0 -> emit value word directly;
//     count>0 -> emit count word, hold sample in pend register, count<=0 -> S_PEND.
//   S_PEND: sti_tready=0; on count word accepted, load pend as value word -> S_RUN (S_IDLE if tlast).
//   Value word with tlast: after it, prev invalidated -> S_IDLE. tlast/trigger ride on the value word only.
//   Count word never carries trigger or tlast.
//  Boundaries: saturation and break same cycle -> count word includes current run, break rule applies;
//   back-pressure in S_PEND holds both words, none lost; cfg_* change only while idle (not checked).
//  Throughput: 1 word/cycle except 1 stall cycle per break that has count>0.
// CONFIGURATION
//  RLE_ENC_STATS_EN defined: adds outputs sts_in_cnt[31:0] (accepted inputs) and
//   sts_out_cnt[31:0] (accepted outputs), wrap at 2^32, cleared by rst and ctl_arm.
//  Undefined: ports absent, no counters synthesised.
// STRUCTURE
//  Package rle_pkg: state enum {S_IDLE,S_RUN,S_PEND}, RLE_FLAG bit index, count-word build function.
//  Sub-module stream_reg: one-entry output register slice (valid/ready, tlast, trigger, data).
//  Top: compare, counter, state machine, pend register (data, tlast, trigger).
// TESTING
//  1. cfg_ena=0; A,A,B,B(tlast) -> A,A,B,B(tlast), latency 1, no stalls.
//  2. cfg_ena=1; A,A,A,A,B(tlast) -> A, 0x8000_0003, B(tlast); one sti_tready stall.
//  3. cfg_limit=4; 10xA then B -> A, 0x8000_0004, 0x8000_0004, 0x8000_0001, B.
//  4. A,A,A(trigger),A,B -> A, 0x8000_0001, A(trigger), 0x8000_0001, B.
//  5. sto_tready=0 for 3 cycles in S_PEND -> sti_tready=0 throughout, count then value word, no loss.
//  6. cfg_mask=0x0000_00FF; 0x1234_0055, 0x7FFF_0055, 0x0000_0066 -> 0x1234_0055, 0x8000_0001, 0x0000_0066.
//  Also: rst asserted in S_PEND -> outputs 0 immediately; first sample after release emitted as value.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and helpers for the run-length stream encoder.
// Holds the FSM state type, the RLE flag position and the count-word builder.
package rle_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } rle_state_e;

    localparam int RLE_DW_DEFAULT = 32;
    localparam int RLE_FLAG       = RLE_DW_DEFAULT - 1;
    localparam int RLE_WORD_MAX   = 64;

    // Callers zero-extend the run count in and truncate the result to their word width.
    function automatic logic [RLE_WORD_MAX-1:0] rle_count_word(
        input logic [RLE_WORD_MAX-1:0] cnt,
        input int                      dw
    );
        logic [RLE_WORD_MAX-1:0] word;
        word         = cnt;
        word[dw-1]   = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/rle_stream_enc_stream_reg.sv
// One-entry registered stream slice (valid/ready) carrying data, tlast and trigger.
// Accepts a new word whenever it is empty or its current word is taken the same cycle.
module stream_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_last_i,
    input  logic          in_trig_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_last_o,
    output logic          out_trig_o,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q;
    logic          last_q;
    logic          trig_q;
    logic [DW-1:0] data_q;
    logic          load;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign load       = in_valid_i & in_ready_o;

    // Payload only changes on load, so it stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            trig_q  <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            trig_q  <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            last_q  <= in_last_i;
            trig_q  <= in_trig_i;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign out_trig_o  = trig_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/rle_stream_enc.sv
// Run-length encoder for the capture sample stream: value words (MSB=0) plus count words (MSB=1).
// Optional statistics counters are compiled in when RLE_ENC_STATS_EN is defined.
module rle_stream_enc
    import rle_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_ena,
    input  logic [DW-1:0] cfg_mask,
    input  logic [CW-1:0] cfg_limit,
    input  logic          ctl_arm,
    output logic          sti_tready,
    input  logic          sti_tvalid,
    input  logic          sti_tlast,
    input  logic          sti_trigger,
    input  logic [DW-1:0] sti_tdata,
    input  logic          sto_tready,
    output logic          sto_tvalid,
    output logic          sto_tlast,
    output logic          sto_trigger,
`ifdef RLE_ENC_STATS_EN
    output logic [31:0]   sts_in_cnt,
    output logic [31:0]   sts_out_cnt,
`endif
    output logic [DW-1:0] sto_tdata
);

    generate
        if (CW > DW - 1 || DW > RLE_WORD_MAX) begin : gen_bad_cfg
            $error("rle_stream_enc: CW must be <= DW-1 and DW <= 64");
        end
    endgenerate

    localparam logic [DW-1:0] FLAG_MASK = {1'b1, {(DW-1){1'b0}}};

    rle_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [DW-2:0] pendData_q, pendData_d;
    logic          pendLast_q, pendLast_d;
    logic          pendTrig_q, pendTrig_d;

    logic          slotFree;
    logic          stiAccept;
    logic          sampleEq;
    logic          runExtend;
    logic [CW-1:0] limitEff;
    logic [CW-1:0] countInc;
    logic [DW-1:0] valueWord;
    logic [DW-1:0] countWordCur;
    logic [DW-1:0] countWordInc;

    logic          pushValid;
    logic          pushLast;
    logic          pushTrig;
    logic [DW-1:0] pushData;

    assign sti_tready = slotFree & (state_q != S_PEND);
    assign stiAccept  = sti_tvalid & sti_tready;

    assign sampleEq  = (((sti_tdata ^ prev_q) & cfg_mask & ~FLAG_MASK) == '0);
    assign runExtend = sampleEq & ~sti_trigger & ~sti_tlast;

    // A zero limit selects the largest run the counter can hold.
    assign limitEff = (cfg_limit == '0) ? '1 : cfg_limit;
    assign countInc = count_q + CW'(1);

    assign valueWord    = {1'b0, sti_tdata[DW-2:0]};
    assign countWordCur = DW'(rle_count_word(RLE_WORD_MAX'(count_q), DW));
    assign countWordInc = DW'(rle_count_word(RLE_WORD_MAX'(countInc), DW));

    // Next-state logic: decide what, if anything, goes into the output slice this cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        prev_d     = prev_q;
        pendData_d = pendData_q;
        pendLast_d = pendLast_q;
        pendTrig_d = pendTrig_q;
        pushValid  = 1'b0;
        pushData   = '0;
        pushLast   = 1'b0;
        pushTrig   = 1'b0;

        if (!cfg_ena) begin
            state_d = S_IDLE;
            count_d = '0;
            if (stiAccept) begin
                pushValid = 1'b1;
                pushData  = sti_tdata;
                pushLast  = sti_tlast;
                pushTrig  = sti_trigger;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stiAccept) begin
                        pushValid = 1'b1;
                        pushData  = valueWord;
                        pushLast  = sti_tlast;
                        pushTrig  = sti_trigger;
                        prev_d    = sti_tdata;
                        count_d   = '0;
                        state_d   = sti_tlast ? S_IDLE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (stiAccept) begin
                        if (runExtend) begin
                            if (countInc == limitEff) begin
                                pushValid = 1'b1;
                                pushData  = countWordInc;
                                count_d   = '0;
                            end else begin
                                count_d = countInc;
                            end
                        end else if (count_q == '0) begin
                            pushValid = 1'b1;
                            pushData  = valueWord;
                            pushLast  = sti_tlast;
                            pushTrig  = sti_trigger;
                            prev_d    = sti_tdata;
                            state_d   = sti_tlast ? S_IDLE : S_RUN;
                        end else begin
                            // Breaking sample waits in the pend register behind its run's count word.
                            pushValid  = 1'b1;
                            pushData   = countWordCur;
                            pendData_d = sti_tdata[DW-2:0];
                            pendLast_d = sti_tlast;
                            pendTrig_d = sti_trigger;
                            count_d    = '0;
                            state_d    = S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (slotFree) begin
                        pushValid = 1'b1;
                        pushData  = {1'b0, pendData_q};
                        pushLast  = pendLast_q;
                        pushTrig  = pendTrig_q;
                        prev_d    = {1'b0, pendData_q};
                        state_d   = pendLast_q ? S_IDLE : S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            prev_q     <= '0;
            pendData_q <= '0;
            pendLast_q <= 1'b0;
            pendTrig_q <= 1'b0;
        end else if (ctl_arm) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            prev_q     <= '0;
            pendData_q <= '0;
            pendLast_q <= 1'b0;
            pendTrig_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prev_q     <= prev_d;
            pendData_q <= pendData_d;
            pendLast_q <= pendLast_d;
            pendTrig_q <= pendTrig_d;
        end
    end

    stream_reg #(
        .DW (DW)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst),
        .clr_i       (ctl_arm),
        .in_valid_i  (pushValid),
        .in_ready_o  (slotFree),
        .in_last_i   (pushLast),
        .in_trig_i   (pushTrig),
        .in_data_i   (pushData),
        .out_valid_o (sto_tvalid),
        .out_ready_i (sto_tready),
        .out_last_o  (sto_tlast),
        .out_trig_o  (sto_trigger),
        .out_data_o  (sto_tdata)
    );

`ifdef RLE_ENC_STATS_EN
    logic [31:0] stsIn_q;
    logic [31:0] stsOut_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stsIn_q  <= '0;
            stsOut_q <= '0;
        end else if (ctl_arm) begin
            stsIn_q  <= '0;
            stsOut_q <= '0;
        end else begin
            if (stiAccept) begin
                stsIn_q <= stsIn_q + 32'd1;
            end
            if (sto_tvalid & sto_tready) begin
                stsOut_q <= stsOut_q + 32'd1;
            end
        end
    end

    assign sts_in_cnt  = stsIn_q;
    assign sts_out_cnt = stsOut_q;
`endif

endmodule

// File: tb/tb_rle_stream_enc.sv
// Directed self-checking bench for rle_stream_enc: pass-through, run encoding,
// saturation, trigger breaks, back-pressure, masking, arm and reset while pending.
module tb_rle_stream_enc;

    localparam int DW = 32;
    localparam int CW = 16;

    localparam logic [31:0] VA  = 32'h0000_00AA;
    localparam logic [31:0] VB  = 32'h0000_00BB;
    localparam logic [31:0] VC  = 32'h0000_00CC;
    localparam logic [31:0] PA  = 32'hC000_00AA;
    localparam logic [31:0] PB  = 32'h8000_00BB;

    logic          clk;
    logic          rst;
    logic          cfg_ena;
    logic [DW-1:0] cfg_mask;
    logic [CW-1:0] cfg_limit;
    logic          ctl_arm;
    logic          sti_tready;
    logic          sti_tvalid;
    logic          sti_tlast;
    logic          sti_trigger;
    logic [DW-1:0] sti_tdata;
    logic          sto_tready;
    logic          sto_tvalid;
    logic          sto_tlast;
    logic          sto_trigger;
    logic [DW-1:0] sto_tdata;
`ifdef RLE_ENC_STATS_EN
    logic [31:0]   sts_in_cnt;
    logic [31:0]   sts_out_cnt;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int stallCount = 0;

    logic [33:0] gotQ[$];
    logic [33:0] expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rle_stream_enc #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_ena     (cfg_ena),
        .cfg_mask    (cfg_mask),
        .cfg_limit   (cfg_limit),
        .ctl_arm     (ctl_arm),
        .sti_tready  (sti_tready),
        .sti_tvalid  (sti_tvalid),
        .sti_tlast   (sti_tlast),
        .sti_trigger (sti_trigger),
        .sti_tdata   (sti_tdata),
        .sto_tready  (sto_tready),
        .sto_tvalid  (sto_tvalid),
        .sto_tlast   (sto_tlast),
        .sto_trigger (sto_trigger),
`ifdef RLE_ENC_STATS_EN
        .sts_in_cnt  (sts_in_cnt),
        .sts_out_cnt (sts_out_cnt),
`endif
        .sto_tdata   (sto_tdata)
    );

    // Record every output word that completes a handshake at the coming edge.
    always @(negedge clk) begin
        if (rst && sto_tvalid && sto_tready) begin
            gotQ.push_back({sto_trigger, sto_tlast, sto_tdata});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic l, input logic t);
        int waitCycles;
        sti_tdata   = d;
        sti_tlast   = l;
        sti_trigger = t;
        sti_tvalid  = 1'b1;
        waitCycles  = 0;
        @(negedge clk);
        while (!sti_tready && waitCycles < 20) begin
            stallCount++;
            waitCycles++;
            @(negedge clk);
        end
        if (!sti_tready) begin
            checkOutput("acceptTimeout", 64'(sti_tready), 64'h1);
        end
        @(posedge clk);
        #1;
        sti_tvalid  = 1'b0;
        sti_tlast   = 1'b0;
        sti_trigger = 1'b0;
    endtask

    task automatic expectWord(input logic t, input logic l, input logic [31:0] d);
        expQ.push_back({t, l, d});
    endtask

    task automatic checkQueue(input string tag);
        checkOutput({tag, ".count"}, 64'(gotQ.size()), 64'(expQ.size()));
        foreach (expQ[i]) begin
            checkOutput($sformatf("%s.word%0d", tag, i),
                        (i < gotQ.size()) ? 64'(gotQ[i]) : 64'hDEAD_DEAD_DEAD_DEAD,
                        64'(expQ[i]));
        end
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic idleCycles(input int n);
        sti_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseArm();
        ctl_arm = 1'b1;
        @(posedge clk);
        #1;
        ctl_arm = 1'b0;
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        rst         = 1'b0;
        cfg_ena     = 1'b0;
        cfg_mask    = '1;
        cfg_limit   = '0;
        ctl_arm     = 1'b0;
        sti_tvalid  = 1'b0;
        sti_tlast   = 1'b0;
        sti_trigger = 1'b0;
        sti_tdata   = '0;
        sto_tready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.valid", 64'(sto_tvalid), 64'h0);
        checkOutput("reset.data", 64'(sto_tdata), 64'h0);
        checkOutput("reset.last", 64'(sto_tlast), 64'h0);
        checkOutput("reset.trigger", 64'(sto_trigger), 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] pass-through");
        cfg_ena    = 1'b0;
        stallCount = 0;
        applyStimulus(PA, 1'b0, 1'b0);
        checkOutput("t1.latValid", 64'(sto_tvalid), 64'h1);
        checkOutput("t1.latData", 64'(sto_tdata), 64'(PA));
        applyStimulus(PA, 1'b0, 1'b0);
        applyStimulus(PB, 1'b0, 1'b0);
        applyStimulus(PB, 1'b1, 1'b0);
        idleCycles(4);
        checkOutput("t1.stalls", 64'(stallCount), 64'h0);
        expectWord(1'b0, 1'b0, PA);
        expectWord(1'b0, 1'b0, PA);
        expectWord(1'b0, 1'b0, PB);
        expectWord(1'b0, 1'b1, PB);
        checkQueue("t1");

        $display("[TB] basic run");
        pulseArm();
        cfg_ena = 1'b1;
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VB, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2.stall", 64'(sti_tready), 64'h0);
        @(negedge clk);
        checkOutput("t2.resume", 64'(sti_tready), 64'h1);
        idleCycles(4);
        expectWord(1'b0, 1'b0, VA);
        expectWord(1'b0, 1'b0, 32'h8000_0003);
        expectWord(1'b0, 1'b1, VB);
        checkQueue("t2");

        $display("[TB] saturation");
        pulseArm();
        cfg_limit  = 16'd4;
        stallCount = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(VA, 1'b0, 1'b0);
        end
        applyStimulus(VB, 1'b0, 1'b0);
        idleCycles(4);
        checkOutput("t3.stalls", 64'(stallCount), 64'h0);
        expectWord(1'b0, 1'b0, VA);
        expectWord(1'b0, 1'b0, 32'h8000_0004);
        expectWord(1'b0, 1'b0, 32'h8000_0004);
        expectWord(1'b0, 1'b0, 32'h8000_0001);
        expectWord(1'b0, 1'b0, VB);
        checkQueue("t3");
        cfg_limit = '0;

        $display("[TB] trigger break");
        pulseArm();
        stallCount = 0;
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b1);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VB, 1'b0, 1'b0);
        idleCycles(4);
        checkOutput("t4.stalls", 64'(stallCount), 64'h1);
        expectWord(1'b0, 1'b0, VA);
        expectWord(1'b0, 1'b0, 32'h8000_0001);
        expectWord(1'b1, 1'b0, VA);
        expectWord(1'b0, 1'b0, 32'h8000_0001);
        expectWord(1'b0, 1'b0, VB);
        checkQueue("t4");

        $display("[TB] back-pressure while pending");
        pulseArm();
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VB, 1'b0, 1'b0);
        sto_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t5.inReady%0d", k), 64'(sti_tready), 64'h0);
            checkOutput($sformatf("t5.outValid%0d", k), 64'(sto_tvalid), 64'h1);
            checkOutput($sformatf("t5.outData%0d", k), 64'(sto_tdata), 64'h8000_0002);
        end
        @(posedge clk);
        #1;
        sto_tready = 1'b1;
        idleCycles(4);
        expectWord(1'b0, 1'b0, VA);
        expectWord(1'b0, 1'b0, 32'h8000_0002);
        expectWord(1'b0, 1'b0, VB);
        checkQueue("t5");

        $display("[TB] channel mask");
        pulseArm();
        cfg_mask = 32'h0000_00FF;
        applyStimulus(32'h1234_0055, 1'b0, 1'b0);
        applyStimulus(32'h7FFF_0055, 1'b0, 1'b0);
        applyStimulus(32'h0000_0066, 1'b0, 1'b0);
        idleCycles(4);
        expectWord(1'b0, 1'b0, 32'h1234_0055);
        expectWord(1'b0, 1'b0, 32'h8000_0001);
        expectWord(1'b0, 1'b0, 32'h0000_0066);
        checkQueue("t6");
        cfg_mask = '1;

        $display("[TB] arm while pending");
        pulseArm();
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VB, 1'b0, 1'b0);
        sto_tready = 1'b0;
        ctl_arm    = 1'b1;
        @(posedge clk);
        #1;
        ctl_arm = 1'b0;
        checkOutput("t7.armValid", 64'(sto_tvalid), 64'h0);
        checkOutput("t7.armReady", 64'(sti_tready), 64'h1);
        sto_tready = 1'b1;
        gotQ.delete();
        applyStimulus(VC, 1'b1, 1'b0);
        idleCycles(4);
        expectWord(1'b0, 1'b1, VC);
        checkQueue("t7");

        $display("[TB] reset while pending");
        pulseArm();
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VA, 1'b0, 1'b0);
        applyStimulus(VB, 1'b0, 1'b0);
        sto_tready = 1'b0;
        rst        = 1'b0;
        #1;
        checkOutput("t8.rstValid", 64'(sto_tvalid), 64'h0);
        checkOutput("t8.rstData", 64'(sto_tdata), 64'h0);
        checkOutput("t8.rstLast", 64'(sto_tlast), 64'h0);
        checkOutput("t8.rstTrigger", 64'(sto_trigger), 64'h0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        sto_tready = 1'b1;
        gotQ.delete();
        @(posedge clk);
        #1;
        applyStimulus(VA, 1'b1, 1'b0);
        idleCycles(4);
        expectWord(1'b0, 1'b1, VA);
        checkQueue("t8");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
